// File: rtl/tlb_op_pkg.sv
// Shared types and constants for the CP0-side TLB maintenance initiator.
`ifndef TLB_IDX_BITS
`define TLB_IDX_BITS 4
`endif

package tlb_op_pkg;
  typedef enum logic [1:0] {
    TLBR  = 2'b00,
    TLBWI = 2'b01,
    TLBWR = 2'b10,
    TLBP  = 2'b11
  } tlb_op_t;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} tlb_st_t;

  localparam int          TLB_IDX_W      = `TLB_IDX_BITS;
  localparam logic [31:0] TLB_RAND_RESET = 32'((1 << TLB_IDX_W) - 1);
  localparam logic [15:0] LFSR_SEED      = 16'hACE1;

  typedef struct packed {
    tlb_op_t     op;
    logic [11:0] mask;
    logic [31:0] hi;
    logic [31:0] lo0;
    logic [31:0] lo1;
  } tlb_req_t;
endpackage

// File: rtl/tlb_random_gen.sv
// CP0 Random source: wired-bounded down counter, or a 16-bit LFSR when
// TLB_OP_LFSR_RANDOM_EN is defined.
module tlb_random_gen
  import tlb_op_pkg::*;
#(
  parameter int IDX_BITS = `TLB_IDX_BITS,
  parameter int TLB_NUM  = 1 << IDX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] wired_i,
  input  logic                wired_we,
  output logic [IDX_BITS-1:0] random_o
);
  localparam logic [IDX_BITS-1:0] RAND_MAX = IDX_BITS'(TLB_NUM - 1);

`ifdef TLB_OP_LFSR_RANDOM_EN
  logic [15:0]         r_lfsr;
  logic                w_fb;
  logic [IDX_BITS-1:0] w_cand;

  // Taps 16,14,13,11 of x^16+x^14+x^13+x^11+1, shifting toward the MSB.
  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (rst || wired_we) r_lfsr <= LFSR_SEED;
    else                 r_lfsr <= {r_lfsr[14:0], w_fb};
  end

  assign w_cand   = r_lfsr[IDX_BITS-1:0];
  assign random_o = (w_cand < wired_i) ? RAND_MAX : w_cand;
`else
  logic [IDX_BITS-1:0] r_rand;

  // Reload covers reset, a Wired write, a saturated Wired and the wrap point.
  always_ff @(posedge clk) begin
    if (rst || wired_we || (wired_i >= RAND_MAX) || (r_rand == wired_i))
      r_rand <= RAND_MAX;
    else
      r_rand <= r_rand - 1'b1;
  end

  assign random_o = r_rand;
`endif
endmodule

// File: rtl/tlb_op_unit.sv
// TLBR/TLBWI/TLBWR/TLBP initiator between the CP0 handler and the TLB port.
// Build option TLB_OP_LFSR_RANDOM_EN selects the LFSR Random source.
module tlb_op_unit
  import tlb_op_pkg::*;
#(
  parameter int IDX_BITS = `TLB_IDX_BITS,
  parameter int TLB_NUM  = 1 << IDX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [1:0]          op_code,
  output logic                done,
  input  logic [31:0]         cp0_index_i,
  input  logic [31:0]         cp0_entryhi_i,
  input  logic [31:0]         cp0_entrylo0_i,
  input  logic [31:0]         cp0_entrylo1_i,
  input  logic [11:0]         cp0_pagemask_i,
  input  logic [IDX_BITS-1:0] wired_i,
  input  logic                wired_we,
  output logic [31:0]         random_o,
  output logic                tlb_we,
  output logic [31:0]         tlb_index_o,
  output logic [11:0]         tlb_mask_o,
  output logic [31:0]         tlb_entryhi_o,
  output logic [31:0]         tlb_entrylo0_o,
  output logic [31:0]         tlb_entrylo1_o,
  input  logic [11:0]         tlb_mask_i,
  input  logic [31:0]         tlb_entryhi_i,
  input  logic [31:0]         tlb_entrylo0_i,
  input  logic [31:0]         tlb_entrylo1_i,
  input  logic [31:0]         tlb_probe_index_i,
  output logic                wb_index_we,
  output logic [31:0]         wb_index,
  output logic                wb_entry_we,
  output logic [31:0]         wb_entryhi,
  output logic [31:0]         wb_entrylo0,
  output logic [31:0]         wb_entrylo1,
  output logic [11:0]         wb_mask
);
  tlb_st_t             r_st, w_st_nxt;
  tlb_req_t            r_req;
  tlb_op_t             w_op_in;
  logic [IDX_BITS-1:0] r_idx, w_rand;
  logic                w_accept;
  logic                w_unused;

  assign w_unused = ^cp0_index_i[31:IDX_BITS];

  tlb_random_gen #(.IDX_BITS(IDX_BITS), .TLB_NUM(TLB_NUM)) u_rand (
    .clk      (clk),
    .rst      (rst),
    .wired_i  (wired_i),
    .wired_we (wired_we),
    .random_o (w_rand)
  );

  assign random_o = 32'(w_rand);
  assign w_op_in  = tlb_op_t'(op_code);
  assign w_accept = (r_st == ST_IDLE) && op_valid;

  always_ff @(posedge clk) begin
    if (rst) r_st <= ST_IDLE;
    else     r_st <= w_st_nxt;
  end

  // Strobes are masked by rst so a reset cycle never commits a write-back.
  always_comb begin
    w_st_nxt    = r_st;
    op_ready    = 1'b0;
    done        = 1'b0;
    tlb_we      = 1'b0;
    wb_entry_we = 1'b0;
    wb_index_we = 1'b0;
    case (r_st)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) w_st_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        tlb_we   = !rst && ((r_req.op == TLBWI) || (r_req.op == TLBWR));
        w_st_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = !rst;
        wb_entry_we = !rst && (r_req.op == TLBR);
        wb_index_we = !rst && (r_req.op == TLBP);
        w_st_nxt    = ST_IDLE;
      end
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req       <= '0;
      r_idx       <= '0;
      wb_index    <= '0;
      wb_entryhi  <= '0;
      wb_entrylo0 <= '0;
      wb_entrylo1 <= '0;
      wb_mask     <= '0;
    end else begin
      if (w_accept) begin
        r_req.op   <= w_op_in;
        r_req.mask <= cp0_pagemask_i;
        r_req.hi   <= cp0_entryhi_i;
        r_req.lo0  <= cp0_entrylo0_i;
        r_req.lo1  <= cp0_entrylo1_i;
        // TLBWR takes Random as it stood before any same-cycle Wired write.
        r_idx      <= (w_op_in == TLBWR) ? w_rand : cp0_index_i[IDX_BITS-1:0];
      end
      if ((r_st == ST_EXEC) && (r_req.op == TLBR)) begin
        wb_mask     <= tlb_mask_i;
        wb_entryhi  <= tlb_entryhi_i;
        wb_entrylo0 <= tlb_entrylo0_i;
        wb_entrylo1 <= tlb_entrylo1_i;
      end
      if ((r_st == ST_EXEC) && (r_req.op == TLBP))
        wb_index <= tlb_probe_index_i;
    end
  end

  assign tlb_index_o    = 32'(r_idx);
  assign tlb_mask_o     = r_req.mask;
  assign tlb_entryhi_o  = r_req.hi;
  assign tlb_entrylo0_o = r_req.lo0;
  assign tlb_entrylo1_o = r_req.lo1;
endmodule

// File: tb/tb_tlb_op_unit.sv
// Randomised bench for tlb_op_unit (IDX_BITS=4) against a transaction-level model.
module tb_tlb_op_unit;
  localparam int RMAX = 15;

  logic        clk = 1'b0;
  logic        rst, op_valid, op_ready, done, wired_we, tlb_we;
  logic [1:0]  op_code;
  logic [31:0] cp0_index_i, cp0_entryhi_i, cp0_entrylo0_i, cp0_entrylo1_i;
  logic [11:0] cp0_pagemask_i, tlb_mask_o, tlb_mask_i, wb_mask;
  logic [3:0]  wired_i;
  logic [31:0] random_o, tlb_index_o, tlb_entryhi_o, tlb_entrylo0_o, tlb_entrylo1_o;
  logic [31:0] tlb_entryhi_i, tlb_entrylo0_i, tlb_entrylo1_i, tlb_probe_index_i;
  logic        wb_index_we, wb_entry_we;
  logic [31:0] wb_index, wb_entryhi, wb_entrylo0, wb_entrylo1;

  always #5 clk = ~clk;

  tlb_op_unit #(.IDX_BITS(4)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .done(done), .cp0_index_i(cp0_index_i), .cp0_entryhi_i(cp0_entryhi_i),
    .cp0_entrylo0_i(cp0_entrylo0_i), .cp0_entrylo1_i(cp0_entrylo1_i),
    .cp0_pagemask_i(cp0_pagemask_i), .wired_i(wired_i), .wired_we(wired_we),
    .random_o(random_o), .tlb_we(tlb_we), .tlb_index_o(tlb_index_o),
    .tlb_mask_o(tlb_mask_o), .tlb_entryhi_o(tlb_entryhi_o),
    .tlb_entrylo0_o(tlb_entrylo0_o), .tlb_entrylo1_o(tlb_entrylo1_o),
    .tlb_mask_i(tlb_mask_i), .tlb_entryhi_i(tlb_entryhi_i),
    .tlb_entrylo0_i(tlb_entrylo0_i), .tlb_entrylo1_i(tlb_entrylo1_i),
    .tlb_probe_index_i(tlb_probe_index_i), .wb_index_we(wb_index_we),
    .wb_index(wb_index), .wb_entry_we(wb_entry_we), .wb_entryhi(wb_entryhi),
    .wb_entrylo0(wb_entrylo0), .wb_entrylo1(wb_entrylo1), .wb_mask(wb_mask)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: cycles since accept (0 = free), the accepted request, the
  // write-back data and the Random value.
  int          m_age;
  int          m_rand;
  logic [1:0]  m_op;
  logic [31:0] m_idx, m_hi, m_lo0, m_lo1, m_whi, m_wlo0, m_wlo1, m_widx;
  logic [11:0] m_mask, m_wmask;
  bit          m_chk_on = 0;

  task automatic check_outs();
    bit wr;
    wr = (m_op == 2'b01) || (m_op == 2'b10);
    chk("op_ready",    op_ready,       m_age == 0);
    chk("done",        done,           m_age == 2 && !rst);
    chk("tlb_we",      tlb_we,         m_age == 1 && wr && !rst);
    chk("wb_entry_we", wb_entry_we,    m_age == 2 && m_op == 2'b00 && !rst);
    chk("wb_index_we", wb_index_we,    m_age == 2 && m_op == 2'b11 && !rst);
    chk("random_o",    random_o,       32'(m_rand));
    chk("tlb_index_o", tlb_index_o,    m_idx);
    chk("tlb_mask_o",  tlb_mask_o,     m_mask);
    chk("tlb_hi_o",    tlb_entryhi_o,  m_hi);
    chk("tlb_lo0_o",   tlb_entrylo0_o, m_lo0);
    chk("tlb_lo1_o",   tlb_entrylo1_o, m_lo1);
    chk("wb_index",    wb_index,       m_widx);
    chk("wb_entryhi",  wb_entryhi,     m_whi);
    chk("wb_entrylo0", wb_entrylo0,    m_wlo0);
    chk("wb_entrylo1", wb_entrylo1,    m_wlo1);
    chk("wb_mask",     wb_mask,        m_wmask);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_age = 0; m_op = 0; m_idx = 0; m_hi = 0; m_lo0 = 0; m_lo1 = 0; m_mask = 0;
      m_whi = 0; m_wlo0 = 0; m_wlo1 = 0; m_widx = 0; m_wmask = 0; m_rand = RMAX;
    end else begin
      if (m_age == 0) begin
        if (op_valid) begin
          m_op   = op_code;
          m_idx  = (op_code == 2'b10) ? 32'(m_rand) : (cp0_index_i & 32'hF);
          m_hi   = cp0_entryhi_i; m_lo0 = cp0_entrylo0_i; m_lo1 = cp0_entrylo1_i;
          m_mask = cp0_pagemask_i;
          m_age  = 1;
        end
      end else if (m_age == 1) begin
        if (m_op == 2'b00) begin
          m_whi = tlb_entryhi_i; m_wlo0 = tlb_entrylo0_i;
          m_wlo1 = tlb_entrylo1_i; m_wmask = tlb_mask_i;
        end
        if (m_op == 2'b11) m_widx = tlb_probe_index_i;
        m_age = 2;
      end else begin
        m_age = 0;
      end
      if (wired_we || int'(wired_i) >= RMAX || m_rand == int'(wired_i)) m_rand = RMAX;
      else m_rand = (m_rand + 15) % 16;
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 2 ns later.
  task automatic step();
    #2;
    if (m_chk_on) check_outs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] idx, input logic [31:0] hi,
                       input logic [31:0] lo0, input logic [31:0] lo1);
    op_valid = 1; op_code = op; cp0_index_i = idx;
    cp0_entryhi_i = hi; cp0_entrylo0_i = lo0; cp0_entrylo1_i = lo1;
    step();
    op_valid = 0;
    step();
    step();
  endtask

  task automatic wait_rand(input int v);
    int k;
    k = 0;
    while (m_rand != v && k < 40) begin
      step();
      k++;
    end
    chk("wait_rand", random_o, 32'(v));
  endtask

  initial begin
    rst = 1; op_valid = 0; op_code = 0; cp0_index_i = 0; cp0_entryhi_i = 0;
    cp0_entrylo0_i = 0; cp0_entrylo1_i = 0; cp0_pagemask_i = 0; wired_i = 4; wired_we = 0;
    tlb_mask_i = 0; tlb_entryhi_i = 0; tlb_entrylo0_i = 0; tlb_entrylo1_i = 0;
    tlb_probe_index_i = 0;
    @(negedge clk);
    step();
    m_chk_on = 1;
    step();
    rst = 0;

    // Random walks 15..4 then wraps back to 15 with Wired=4.
    repeat (14) step();

    cp0_pagemask_i = 12'h003;
    issue(2'b01, 32'd5, 32'h0040_2001, 32'h0000_1017, 32'h0000_1057);

    tlb_probe_index_i = 32'h8000_0000;
    issue(2'b11, 32'd0, 32'h0000_2000, 32'd0, 32'd0);
    chk("tlbp_miss_hold", wb_index, 32'h8000_0000);
    tlb_probe_index_i = 32'd3;
    issue(2'b11, 32'd0, 32'h0000_4000, 32'd0, 32'd0);
    chk("tlbp_hit_hold", wb_index, 32'd3);

    tlb_entryhi_i = 32'h1234_6001; tlb_entrylo0_i = 32'h0000_2017;
    tlb_entrylo1_i = 32'h0000_2057; tlb_mask_i = 12'h00F;
    issue(2'b00, 32'd7, 32'd0, 32'd0, 32'd0);
    tlb_entryhi_i = 32'hDEAD_0000;
    step(); step();
    chk("tlbr_hold", wb_entryhi, 32'h1234_6001);

    // TLBWR picks up the live Random value.
    wait_rand(9);
    op_valid = 1; op_code = 2'b10; cp0_index_i = 32'd2;
    step();
    op_valid = 0;
    chk("twr_idx", tlb_index_o, 32'd9);
    step(); step();

    wait_rand(9);
    wired_we = 1;
    step();
    wired_we = 0;
    chk("wired_we_reload", random_o, 32'd15);

    // TLBWR and Wired write together: index is the pre-write Random.
    wait_rand(9);
    wired_we = 1; op_valid = 1; op_code = 2'b10;
    step();
    wired_we = 0; op_valid = 0;
    chk("twr_prewired", tlb_index_o, 32'd9);
    step(); step();

    // Reset while a TLBWI is in EXEC.
    op_valid = 1; op_code = 2'b01; cp0_index_i = 32'd6;
    step();
    op_valid = 0; rst = 1;
    step();
    rst = 0;
    chk("rst_exec_ready", op_ready, 32'd1);
    step(); step();

    // op_valid held: one accept every third cycle, op_code sampled per accept.
    op_valid = 1; op_code = 2'b01; tlb_probe_index_i = 32'd5;
    step();
    op_code = 2'b11;
    repeat (5) step();
    op_valid = 0;
    step(); step(); step();

    for (int i = 0; i < 500; i++) begin
      op_valid          = 1'($urandom_range(0, 1));
      op_code           = 2'($urandom);
      cp0_index_i       = $urandom;
      cp0_entryhi_i     = $urandom;
      cp0_entrylo0_i    = $urandom;
      cp0_entrylo1_i    = $urandom;
      cp0_pagemask_i    = 12'($urandom);
      tlb_mask_i        = 12'($urandom);
      tlb_entryhi_i     = $urandom;
      tlb_entrylo0_i    = $urandom;
      tlb_entrylo1_i    = $urandom;
      tlb_probe_index_i = $urandom;
      wired_we          = ($urandom_range(0, 15) == 0);
      if (wired_we) wired_i = 4'($urandom_range(0, 15));
      rst               = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 0; op_valid = 0; wired_we = 0;
    step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tlb_op_unit.md
Name: tlb_op_unit

Overview:
- CP0-side initiator for the TLB write/read/probe port; executes TLBR, TLBWI, TLBWR and TLBP for the pipeline.
- Latches CP0 EntryHi/EntryLo0/EntryLo1/PageMask/Index, drives the TLB maintenance interface and captures read/probe results.
- Owns the Random register and returns write-back strobes to CP0; sits between the EX-stage CP0 instruction handler and the TLB.

Parameters:
IDX_BITS, `TLB_IDX_BITS, TLB index width
TLB_NUM, 1 << IDX_BITS, number of TLB entries

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
op_valid  in  1  operation request
op_ready  out  1  unit can accept an operation
op_code  in  2  00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP
done  out  1  one-cycle completion pulse
cp0_index_i  in  32  CP0 Index register
cp0_entryhi_i  in  32  CP0 EntryHi register
cp0_entrylo0_i  in  32  CP0 EntryLo0 register
cp0_entrylo1_i  in  32  CP0 EntryLo1 register
cp0_pagemask_i  in  12  CP0 PageMask[24:13]
wired_i  in  IDX_BITS  CP0 Wired value
wired_we  in  1  CP0 Wired register write this cycle
random_o  out  32  Random register value, zero-extended
tlb_we  out  1  TLB write enable
tlb_index_o  out  32  TLB index
tlb_mask_o  out  12  mask to TLB
tlb_entryhi_o  out  32  EntryHi to TLB; also used as the probe key
tlb_entrylo0_o  out  32  EntryLo0 to TLB
tlb_entrylo1_o  out  32  EntryLo1 to TLB
tlb_mask_i  in  12  read mask from TLB
tlb_entryhi_i  in  32  read EntryHi from TLB
tlb_entrylo0_i  in  32  read EntryLo0 from TLB
tlb_entrylo1_i  in  32  read EntryLo1 from TLB
tlb_probe_index_i  in  32  probe result; bit31 = miss
wb_index_we  out  1  CP0 Index write strobe (TLBP)
wb_index  out  32  CP0 Index write data
wb_entry_we  out  1  CP0 EntryHi/EntryLo0/EntryLo1/PageMask write strobe (TLBR)
wb_entryhi, wb_entrylo0, wb_entrylo1  out  32 each  TLBR write data
wb_mask  out  12  TLBR PageMask write data

Behaviour:
- FSM states: IDLE, EXEC, DONE.
- IDLE: op_ready=1. On op_valid, latch op_code and all cp0_* inputs. Index is cp0_index_i[IDX_BITS-1:0], or Random's current value for TLBR-free TLBWR. Go to EXEC.
- EXEC: op_ready=0. tlb_* outputs are driven from the latched values; tlb_index_o is zero-extended.
  - TLBWI/TLBWR: tlb_we=1 for exactly this cycle.
  - TLBR: sample the tlb_mask_i/entryhi/entrylo0/entrylo1 inputs into wb_* registers.
  - TLBP: sample tlb_probe_index_i into wb_index.
  - Go to DONE.
- DONE: done=1.
  - wb_entry_we=1 iff TLBR.
  - wb_index_we=1 iff TLBP.
  - Return to IDLE.
- Latency: accept at cycle 0, TLB write or sample at cycle 1, done at cycle 2. Next accept no earlier than cycle 3.
- tlb_* outputs hold their latched values outside EXEC. tlb_we=0 outside EXEC.
- wb_* data registers hold until the next TLBR/TLBP.
- Random (reset TLB_NUM-1):
  - Decrements every cycle.
  - When Random == wired_i, the next value is TLB_NUM-1.
  - If wired_i >= TLB_NUM-1, Random stays at TLB_NUM-1.
  - wired_we forces TLB_NUM-1 and wins over decrement/wrap in the same cycle.
- A TLBWR accepted in the same cycle as wired_we uses the pre-update Random value.
- Reset values: FSM IDLE; op_ready=1; done=0; tlb_we=0; wb_*_we=0; all data outputs 0; Random=TLB_NUM-1.
- Reset mid-operation: FSM returns to IDLE, no tlb_we, no done, and no wb strobe in the reset cycle or after.
- op_code is sampled only at acceptance; op_valid in non-IDLE states is ignored (not queued).

Optional Feature:
- Macro: TLB_OP_LFSR_RANDOM_EN.
- Defined:
  - Random comes from a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) advanced every cycle.
  - Candidate = LFSR[IDX_BITS-1:0]; if candidate < wired_i, Random = TLB_NUM-1.
  - wired_we reseeds the LFSR.
- Undefined: decrementing counter as above.

Decomposition:
- Package tlb_op_pkg:
  - tlb_op_t enum: TLBR=2'b00, TLBWI=2'b01, TLBWR=2'b10, TLBP=2'b11.
  - FSM state enum.
  - Constants TLB_RAND_RESET and LFSR_SEED.
- Sub-module tlb_random_gen: Random counter/LFSR with wired_i, wired_we and random value output.

Test Plan (IDX_BITS=4):
- TLBWI: Index=5, EntryHi=32'h0040_2001, Lo0=32'h0000_1017, Lo1=32'h0000_1057 -> tlb_we=1 in cycle 1 only, tlb_index_o=5, done in cycle 2, no wb strobes.
- TLBP with TLB returning 32'h8000_0000 -> wb_index_we=1 and wb_index=32'h8000_0000 in cycle 2; a hit returning 3 gives wb_index=3.
- TLBR: Index=7, TLB returns EntryHi=32'h1234_6001 -> wb_entry_we=1 in cycle 2 with the matching wb_* values; data held after done.
- Random:
  - Wired=4: from reset, Random reads 15, 14 … 4, then 15.
  - wired_we while Random=9 -> next 15.
  - TLBWR accepted while Random=9 -> tlb_index_o=9.
- rst asserted during EXEC of TLBWI -> no done, FSM IDLE, op_ready=1 next cycle.
- op_valid held high continuously -> exactly one accept per 3 cycles; the second op_code is sampled at the second accept.
